// File: rtl/button_poll_if.sv
// Avalon-MM read bus between the button poller and the PIO responder.
// Word address, read strobe and 32-bit registered read data.
interface button_poll_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata
  );
endinterface

// File: rtl/button_poll_master.sv
// Periodically reads the button PIO, debounces each bit and
// reports a clean pressed vector with press/release pulses.
module button_poll_master #(
  parameter int WIDTH        = 4,
  parameter int POLL_CYCLES  = 50000,
  parameter int STABLE_COUNT = 4,
  parameter int READ_LATENCY = 1,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             poll_en,
  button_poll_if.master    bus,
  output logic [WIDTH-1:0] pressed,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             sample_valid
);

  localparam int PW = $clog2(POLL_CYCLES);
  localparam int LW =
    (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [WIDTH-1:0] MASK =
    {WIDTH{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    S_WAIT,
    S_READ,
    S_LAT
  } state_t;

  state_t                     state;
  logic [PW-1:0]              poll_cnt;
  logic [LW-1:0]              lat_cnt;
  logic [WIDTH-1:0]           raw;
  logic [WIDTH-1:0][CW-1:0]   cnt;
  logic [WIDTH-1:0]           smp;
  logic [WIDTH-1:0]           nxt_raw;
  logic [WIDTH-1:0][CW-1:0]   nxt_cnt;
  logic [WIDTH-1:0]           nxt_pressed;
  logic                       unused_hi;

  assign bus.avm_address = 2'd0;
  assign unused_hi       = ^bus.avm_readdata;
  assign smp             = bus.avm_readdata[WIDTH-1:0];
  assign nxt_pressed     = nxt_raw ^ MASK;

  // Only consecutive disagreeing samples advance a bit's count.
  always_comb begin
    nxt_raw = raw;
    nxt_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (smp[i] != raw[i]) begin
        if (cnt[i] + 1'b1 == CW'(STABLE_COUNT))
          nxt_raw[i] = ~raw[i];
        else
          nxt_cnt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= S_WAIT;
      poll_cnt      <= PW'(POLL_CYCLES - 1);
      lat_cnt       <= '0;
      raw           <= MASK;
      cnt           <= '0;
      pressed       <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      sample_valid  <= 1'b0;
      bus.avm_read  <= 1'b0;
    end else begin
      sample_valid  <= 1'b0;
      press_pulse   <= '0;
      release_pulse <= '0;
      unique case (state)
        S_WAIT: begin
          if (poll_en) begin
            if (poll_cnt == '0) begin
              state        <= S_READ;
              bus.avm_read <= 1'b1;
            end else begin
              poll_cnt <= poll_cnt - 1'b1;
            end
          end
        end
        S_READ: begin
          bus.avm_read <= 1'b0;
          lat_cnt      <= LW'(READ_LATENCY - 1);
          state        <= S_LAT;
        end
        S_LAT: begin
          if (lat_cnt == '0) begin
            raw           <= nxt_raw;
            cnt           <= nxt_cnt;
            pressed       <= nxt_pressed;
            press_pulse   <= nxt_pressed & ~pressed;
            release_pulse <= ~nxt_pressed & pressed;
            sample_valid  <= 1'b1;
            poll_cnt      <= PW'(POLL_CYCLES - 1);
            state         <= S_WAIT;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: doc/button_poll_master.md
Name: button_poll_master

Overview:
- Avalon-MM read initiator that periodically polls the 4-bit button PIO responder (address 0, registered readdata, no waitrequest).
- Debounces each bit, presents a clean "pressed" vector, and raises one-cycle press/release pulses.
- Sits in the fabric between the button PIO slave and hardware consumers (e.g. drawing-mode logic), offloading polling from the NIOS.

Parameters:
WIDTH, 4, number of button bits taken from readdata[WIDTH-1:0]
POLL_CYCLES, 50000, clock cycles between read issues (min 2)
STABLE_COUNT, 4, consecutive differing samples needed to flip a debounced bit (min 1, max 255)
READ_LATENCY, 1, cycles from avm_read assertion to valid avm_readdata (min 1)
ACTIVE_LOW, 1, 1 = raw input bit 0 means pressed

Ports:
clk  in  1  system clock
reset_n  in  1  reset; synchronous, active-low
poll_en  in  1  enables the interval counter
avm_address  out  2  responder word address; always 0
avm_read  out  1  read strobe, one cycle per poll
avm_readdata  in  32  responder read data; bits above WIDTH-1 ignored
pressed  out  WIDTH  debounced pressed state, 1 = pressed
press_pulse  out  WIDTH  one-cycle pulse per bit on pressed 0->1
release_pulse  out  WIDTH  one-cycle pulse per bit on pressed 1->0
sample_valid  out  1  one-cycle pulse when a sample is captured

Behaviour:
- Clocking: one clock `clk`. Reset `reset_n` is synchronous and active-low; it is sampled only on the rising edge of clk.
- Reset values:
  - pressed, press_pulse, release_pulse = 0; sample_valid = 0; avm_read = 0; avm_address = 0.
  - Internal raw debounced register = all 1 if ACTIVE_LOW, else all 0.
  - Per-bit stability counters = 0; FSM = WAIT; interval counter = POLL_CYCLES-1.
- FSM states:
  - WAIT: if poll_en, interval counter decrements; at 0 (with poll_en high) go to READ. If poll_en is low, the counter holds.
  - READ: avm_read = 1 for exactly one cycle; latency counter loads READ_LATENCY-1; go to LAT.
  - LAT: decrement the latency counter. When it is 0, capture avm_readdata[WIDTH-1:0] on that edge, pulse sample_valid in the following cycle, reload the interval counter to POLL_CYCLES-1, and go to WAIT.
  - With READ_LATENCY=1, the sample is taken at the edge ending the cycle after avm_read.
- Poll period: read issues are exactly POLL_CYCLES+READ_LATENCY+1 cycles apart while poll_en stays high.
- poll_en deasserted during READ or LAT: the in-flight read completes and is captured; the FSM then holds in WAIT.
- Debounce, per bit i, evaluated only on capture:
  - sample[i] == raw[i]: counter[i] = 0.
  - Otherwise counter[i] += 1. When the incremented value equals STABLE_COUNT: raw[i] toggles and counter[i] = 0.
  - A single agreeing sample resets the count (consecutive-only rule).
- Outputs:
  - pressed = raw XOR {WIDTH{ACTIVE_LOW}}, registered; it updates in the same cycle sample_valid is high.
  - press_pulse[i] / release_pulse[i] are high in that same cycle when pressed[i] changes; otherwise 0.
  - Multiple bits may pulse simultaneously.
- Counter widths: sized to hold their maximum value; no wrap is possible because counters reset on reaching their limit.
- Reset asserted mid-read: avm_read drops on the next edge and any pending capture is discarded.

Test Plan:
(Bench parameters: POLL_CYCLES=8, STABLE_COUNT=3, READ_LATENCY=1, ACTIVE_LOW=1.)
1. Reset release, poll_en=1, readdata=0xF constant -> avm_read pulses every 10 cycles; pressed=0; no pulses; avm_address always 0.
2. readdata bit0 goes 0 and stays -> after the 3rd capture, pressed=0x1 with press_pulse=0x1 for one cycle, coincident with sample_valid.
3. Bit0 bounce pattern 0,0,1,0,0 over captures -> no change until the 5th capture completes; then pressed[0] stays 0 (count reached only 2).
4. Bits 1 and 3 released together after being pressed (raw 1 for 3 captures) -> release_pulse=0xA for one cycle; pressed updates to 0x0 for those bits.
5. Drop poll_en in the READ cycle -> capture still occurs; no further avm_read until poll_en returns; the next read follows 8 enabled WAIT cycles later.
6. Assert reset_n=0 in the LAT cycle with readdata=0x0 -> no capture; all outputs 0; counters cleared; polling restarts with a full interval after release.
